// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder
//   Deframes PS/2 keyboard traffic (start, 8 data bits LSB first, odd parity,
//   stop) and turns set-2 scan code sequences into key events. E0 marks the
//   next code as extended and F0 marks it as a break. Repeated makes of the
//   key that is already held are dropped, so downstream logic sees a single
//   make and a single break for every physical key press.
//
// Parameters
//   FILTER_LEN      consecutive equal synchronized ps2_clk samples needed
//                   before the filtered clock changes level
//   TIMEOUT_CYCLES  clk cycles without a falling edge mid-frame before the
//                   frame is abandoned
//   SUPPRESS_REPEAT 1 = drop a repeated make of the currently held key
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   ps2_clk      raw PS/2 clock line (asynchronous)
//   ps2_data     raw PS/2 data line (asynchronous)
//   key_valid    one-cycle pulse per emitted key event
//   last_change  {extended, code[7:0]} of the last event, held between events
//   key_down     1 = last event was a make, 0 = a break
//   frame_err    one-cycle pulse on framing, parity or timeout error

module ps2_scan_decoder #(
  parameter int FILTER_LEN      = 8,
  parameter int TIMEOUT_CYCLES  = 200000,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [8:0] last_change,
  output logic       key_down,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Synchronizers reset to the idle (high) line level so that leaving reset
  // never looks like a falling edge.
  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_s;
  logic       data_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_s    = clk_sync[1];
  assign data_bit = data_sync[1];

  // The counter only advances while the synchronized clock disagrees with the
  // filtered one; any agreeing sample restarts it, so short glitches vanish.
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          filt_flip;
  logic          fall;

  assign filt_flip = (clk_s != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));
  assign fall      = filt_flip && filt_clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      filt_clk <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  // Frame and key-decode state.
  state_t        state, state_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    shift, shift_nx;
  logic          parity_ok, parity_ok_nx;
  logic [TW-1:0] to_cnt, to_cnt_nx;
  logic          ext, ext_nx;
  logic          brk, brk_nx;
  logic          held_valid, held_valid_nx;
  logic [8:0]    held_code, held_code_nx;
  logic          timeout;
  logic          byte_good;
  logic          err_nx;
  logic          emit;
  logic          make;
  logic [8:0]    cand;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      parity_ok   <= 1'b0;
      to_cnt      <= '0;
      ext         <= 1'b0;
      brk         <= 1'b0;
      held_valid  <= 1'b0;
      held_code   <= '0;
      key_valid   <= 1'b0;
      last_change <= '0;
      key_down    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      shift      <= shift_nx;
      parity_ok  <= parity_ok_nx;
      to_cnt     <= to_cnt_nx;
      ext        <= ext_nx;
      brk        <= brk_nx;
      held_valid <= held_valid_nx;
      held_code  <= held_code_nx;
      key_valid  <= emit;
      frame_err  <= err_nx;
      if (emit) begin
        last_change <= cand;
        key_down    <= make;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    bit_cnt_nx    = bit_cnt;
    shift_nx      = shift;
    parity_ok_nx  = parity_ok;
    ext_nx        = ext;
    brk_nx        = brk;
    held_valid_nx = held_valid;
    held_code_nx  = held_code;
    byte_good     = 1'b0;
    err_nx        = 1'b0;
    emit          = 1'b0;
    make          = 1'b0;
    cand          = '0;

    // A falling edge in the same cycle restarts the timeout window instead.
    timeout = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    if (timeout) begin
      state_nx = IDLE;
      err_nx   = 1'b1;
    end else if (fall) begin
      unique case (state)
        IDLE: begin
          if (!data_bit) begin
            state_nx   = DATA;
            bit_cnt_nx = '0;
          end else begin
            err_nx = 1'b1;
          end
        end
        DATA: begin
          shift_nx   = {data_bit, shift[7:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = PARITY;
        end
        PARITY: begin
          parity_ok_nx = ^{shift, data_bit};
          state_nx     = STOP;
        end
        STOP: begin
          state_nx = IDLE;
          if (data_bit && parity_ok) byte_good = 1'b1;
          else err_nx = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end

    to_cnt_nx = (fall || timeout || state == IDLE) ? '0 : to_cnt + TW'(1);

    if (err_nx) begin
      ext_nx = 1'b0;
      brk_nx = 1'b0;
    end else if (byte_good) begin
      case (shift)
        8'hE0: ext_nx = 1'b1;
        8'hF0: brk_nx = 1'b1;
        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
          ext_nx = 1'b0;
          brk_nx = 1'b0;
        end
        default: begin
          cand   = {ext, shift};
          make   = !brk;
          ext_nx = 1'b0;
          brk_nx = 1'b0;
          if (make) begin
            if (!(SUPPRESS_REPEAT != 0 && held_valid && held_code == cand)) begin
              emit          = 1'b1;
              held_valid_nx = 1'b1;
              held_code_nx  = cand;
            end
          end else begin
            emit = 1'b1;
            if (held_valid && held_code == cand) held_valid_nx = 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder
//   Drives PS/2 frames into two decoders that differ only in repeat
//   suppression and compares their events and error pulses with a small
//   model of the key protocol.

module tb_ps2_scan_decoder;

  localparam int FILT = 8;
  localparam int TMO  = 3000;

  logic clk = 1'b0;
  logic rst;
  logic ps2_clk;
  logic ps2_data;

  logic       kv0, kd0, fe0;
  logic [8:0] lc0;
  logic       kv1, kd1, fe1;
  logic [8:0] lc1;

  ps2_scan_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO), .SUPPRESS_REPEAT(1)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_valid(kv0), .last_change(lc0), .key_down(kd0), .frame_err(fe0)
  );

  ps2_scan_decoder #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO), .SUPPRESS_REPEAT(0)) dut_nr (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_valid(kv1), .last_change(lc1), .key_down(kd1), .frame_err(fe1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed activity, sampled on the falling clk edge.
  int   ev0 = 0, ev1 = 0, er0 = 0, er1 = 0, dbl0 = 0, dbl1 = 0, err_cyc = 0;
  logic kv0_prev = 1'b0, kv1_prev = 1'b0;

  always @(negedge clk) begin
    if (kv0) ev0++;
    if (kv1) ev1++;
    if (kv0 && kv0_prev) dbl0++;
    if (kv1 && kv1_prev) dbl1++;
    if (fe0) begin er0++; err_cyc = cyc; end
    if (fe1) er1++;
    kv0_prev = kv0;
    kv1_prev = kv1;
  end

  // Expected behaviour.
  int         exp_ev0 = 0, exp_ev1 = 0, exp_err = 0;
  logic [8:0] exp_lc0 = '0, exp_lc1 = '0;
  logic       exp_kd0 = 1'b0, exp_kd1 = 1'b0;
  logic       m_ext = 1'b0, m_brk = 1'b0, m_hv = 1'b0;
  logic [8:0] m_hc = '0;

  int total = 0;
  int bad   = 0;
  int half  = 20;
  int fall_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  // Sends the first n bits of a frame; bit glitch_bit gets a short low pulse
  // on ps2_clk during its high phase.
  task automatic ps2_bits(input logic [10:0] bits, input int n, input int glitch_bit);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      if (i == glitch_bit) begin
        wait_cycles(5);
        ps2_clk = 1'b0;
        wait_cycles(FILT - 2);
        ps2_clk = 1'b1;
        wait_cycles(half - 5 - (FILT - 2));
      end else begin
        wait_cycles(half);
      end
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      wait_cycles(half);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    logic [8:0] code;
    if (!good) begin
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      code = {m_ext, b};
      exp_ev1++;
      exp_lc1 = code;
      exp_kd1 = !m_brk;
      if (m_brk) begin
        exp_ev0++;
        exp_lc0 = code;
        exp_kd0 = 1'b0;
        if (m_hv && m_hc == code) m_hv = 1'b0;
      end else if (!(m_hv && m_hc == code)) begin
        exp_ev0++;
        exp_lc0 = code;
        exp_kd0 = 1'b1;
        m_hv = 1'b1;
        m_hc = code;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_ext = 1'b0; m_brk = 1'b0; m_hv = 1'b0; m_hc = '0;
    exp_lc0 = '0; exp_lc1 = '0; exp_kd0 = 1'b0; exp_kd1 = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int glitch);
    ps2_bits(frame_bits(b, bad_par, bad_stop), 11, glitch);
    wait_cycles(half + 20);
    model_frame(b, !bad_par && !bad_stop);
  endtask

  task automatic send(input logic [7:0] b);
    apply_stimulus(b, 1'b0, 1'b0, -1);
  endtask

  task automatic check_output(input string tag);
    check({tag, ".ev"},     ev0,     exp_ev0);
    check({tag, ".ev_nr"},  ev1,     exp_ev1);
    check({tag, ".lc"},     lc0,     exp_lc0);
    check({tag, ".kd"},     kd0,     exp_kd0);
    check({tag, ".lc_nr"},  lc1,     exp_lc1);
    check({tag, ".kd_nr"},  kd1,     exp_kd1);
    check({tag, ".err"},    er0,     exp_err);
    check({tag, ".err_nr"}, er1,     exp_err);
    check({tag, ".dbl"},    dbl0 + dbl1, 0);
  endtask

  initial begin
    repeat (200000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int base;
    int lat;
    logic [7:0] code;
    logic [7:0] prev_code;
    bit ext;
    bit brk;

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(10);
    check_output("reset");

    $display("[TB] make/break 69");
    send(8'h69);
    check_output("make69");
    check("make69.lc_const", lc0, 9'h069);
    send(8'hF0); send(8'h69);
    check_output("break69");

    $display("[TB] extended 75");
    send(8'hE0); send(8'h75);
    check_output("make175");
    check("make175.lc_const", lc0, 9'h175);
    send(8'hE0); send(8'hF0); send(8'h75);
    check_output("break175");

    $display("[TB] typematic 72");
    base = ev0;
    n = ev1;
    send(8'h72); send(8'h72); send(8'h72); send(8'hF0); send(8'h72);
    check_output("typematic");
    check("typematic.pulses", ev0 - base, 2);
    check("typematic.pulses_nr", ev1 - n, 4);

    $display("[TB] parity and stop errors");
    apply_stimulus(8'h7A, 1'b1, 1'b0, -1);
    check_output("badpar7A");
    send(8'h7A);
    check_output("good7A");
    apply_stimulus(8'h6B, 1'b0, 1'b1, -1);
    check_output("badstop6B");

    $display("[TB] timeout");
    base = er0;
    ps2_bits(frame_bits(8'h55, 1'b0, 1'b0), 6, -1);
    n = 0;
    while (er0 == base && n < TMO + 200) begin
      wait_cycles(1);
      n++;
    end
    model_frame(8'h00, 1'b0);
    check("timeout.seen", er0, base + 1);
    // Raw edge to processed edge costs two synchronizer stages plus the filter.
    lat = err_cyc - fall_cyc;
    check("timeout.lat", (lat >= TMO + FILT - 1 && lat <= TMO + FILT + 5), 1);
    wait_cycles(20);
    send(8'h1D);
    check_output("after_timeout1D");

    send(8'hF0);
    apply_stimulus(8'h33, 1'b1, 1'b0, -1);
    send(8'h16);
    check_output("brk_cleared16");
    check("brk_cleared16.kd_const", kd0, 1'b1);

    $display("[TB] clock glitch");
    apply_stimulus(8'h5A, 1'b0, 1'b0, 4);
    check_output("glitch5A");

    $display("[TB] reset mid-frame");
    ps2_bits(frame_bits(8'h3C, 1'b0, 1'b0), 4, -1);
    rst = 1'b1;
    #1;
    check("rst.kv", kv0, 1'b0);
    check("rst.lc", lc0, 9'h000);
    check("rst.kd", kd0, 1'b0);
    check("rst.fe", fe0, 1'b0);
    check("rst.lc_nr", lc1, 9'h000);
    check("rst.kd_nr", kd1, 1'b0);
    wait_cycles(3);
    rst = 1'b0;
    ps2_data = 1'b1;
    model_reset();
    wait_cycles(20);
    check_output("after_rst");
    send(8'h22);
    check_output("after_rst22");

    $display("[TB] random key traffic");
    prev_code = 8'h22;
    for (int it = 0; it < 16; it++) begin
      half = $urandom_range(16, 30);
      code = 8'($urandom_range(1, 127));
      if ($urandom_range(0, 7) == 0) code = 8'hE1;
      ext = ($urandom_range(0, 2) == 0);
      brk = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) begin
        code = prev_code;
        brk  = 1'b0;
      end
      prev_code = code;
      if (ext) send(8'hE0);
      if (brk) send(8'hF0);
      send(code);
      check_output($sformatf("rand%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
